fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_slot_fifo.sv | 85 ++++++++
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its
// outstanding-request slot FIFO.
package fetch_pkg;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic        epoch;
    logic        filled;
    logic [31:0] inst;
  } slot_t;

endpackage

// File: rtl/fetch_slot_fifo.sv
// In-order slot FIFO tracking outstanding instruction fetches; responses fill
// slots oldest-first and stale (pre-redirect) slots are discarded on response.
module fetch_slot_fifo
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cur_epoch,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        pop,
  input  logic        flush,
  output logic        full,
  output logic        head_ready,
  output logic [31:0] head_pc,
  output logic [31:0] head_inst
);

  slot_t            slots  [FIFO_DEPTH];
  slot_t            nslots [FIFO_DEPTH];
  logic [PTR_W-1:0] hd, nhd, idx, tail;
  logic [CNT_W-1:0] cnt, ncnt, rm;
  logic             rsp_open;

  // Filled and stale slots always form a prefix of the queue, so every
  // removal (pop, stale drop, flush) just advances the head pointer.
  always_comb begin
    nslots   = slots;
    rm       = '0;
    rsp_open = rsp_valid;
    idx      = hd;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      idx = hd + PTR_W'(i);
      if (CNT_W'(i) < cnt && rsp_open && !nslots[idx].filled) begin
        rsp_open = 1'b0;
        if (nslots[idx].epoch != cur_epoch) begin
          rm = rm + CNT_W'(1);
        end else begin
          nslots[idx].filled = 1'b1;
          nslots[idx].inst   = rsp_data;
        end
      end
    end
    if (pop) rm = rm + CNT_W'(1);
    // Survivors keep the pre-toggle epoch so they read stale afterwards.
    if (flush) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        idx = hd + PTR_W'(i);
        if (CNT_W'(i) < cnt) begin
          if (nslots[idx].filled) rm = rm + CNT_W'(1);
          nslots[idx].epoch = cur_epoch;
        end
      end
    end
    tail = hd + PTR_W'(cnt);
    if (push) begin
      nslots[tail].pc     = push_pc;
      nslots[tail].epoch  = cur_epoch;
      nslots[tail].filled = 1'b0;
      nslots[tail].inst   = '0;
    end
    nhd  = hd + PTR_W'(rm);
    ncnt = cnt - rm + CNT_W'(push);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hd  <= '0;
      cnt <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) slots[i] <= '0;
    end else begin
      hd    <= nhd;
      cnt   <= ncnt;
      slots <= nslots;
    end
  end

  assign full       = (cnt == CNT_W'(FIFO_DEPTH));
  assign head_ready = (cnt != '0) && slots[hd].filled && (slots[hd].epoch == cur_epoch);
  assign head_pc    = slots[hd].pc;
  assign head_inst  = slots[hd].inst;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC/epoch tracking, request issue to instruction
// memory, and the IF/ID pipeline register fed from the slot FIFO.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        IMemReqValidF,
  input  logic        IMemReqReadyF,
  output logic [31:0] IMemAddrF,
  input  logic        IMemRspValidF,
  input  logic [31:0] IMemRdataF,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] InstD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  logic [31:0] pcf;
  logic        epoch;
  logic        full;
  logic        head_ready;
  logic [31:0] head_pc;
  logic [31:0] head_inst;
  logic        accept;
  logic        pop;

  assign IMemReqValidF = !rst && !StallF && !PCSrcE && !full;
  assign IMemAddrF     = pcf;
  assign accept        = IMemReqValidF && IMemReqReadyF;
  assign pop           = !rst && !PCSrcE && !FlushD && !StallD && head_ready;

  fetch_slot_fifo u_slot_fifo (
    .clk        (clk),
    .rst        (rst),
    .cur_epoch  (epoch),
    .push       (accept),
    .push_pc    (pcf),
    .rsp_valid  (IMemRspValidF),
    .rsp_data   (IMemRdataF),
    .pop        (pop),
    .flush      (PCSrcE),
    .full       (full),
    .head_ready (head_ready),
    .head_pc    (head_pc),
    .head_inst  (head_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pcf   <= RESET_PC;
      epoch <= 1'b0;
    end else if (PCSrcE) begin
      pcf   <= PCTargetE & 32'hFFFF_FFFC;
      epoch <= ~epoch;
    end else if (accept) begin
      pcf   <= pcf + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ValidD   <= 1'b0;
      InstD    <= NOP_INST;
      PCD      <= '0;
      PCPlus4D <= '0;
    end else if (PCSrcE || FlushD) begin
      ValidD <= 1'b0;
      InstD  <= NOP_INST;
    end else if (!StallD) begin
      if (head_ready) begin
        ValidD   <= 1'b1;
        InstD    <= head_inst;
        PCD      <= head_pc;
        PCPlus4D <= head_pc + 32'd4;
      end else begin
        ValidD <= 1'b0;
        InstD  <= NOP_INST;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queue-based reference model compared
// every cycle, an in-order memory responder, and directed scenarios.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, rsp_valid;
  logic        stall_f, stall_d, flush_d, pcsrc_e, valid_d;
  logic [31:0] addr, rdata, target, inst_d, pc_d, pcp4_d;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .IMemReqValidF (req_valid),
    .IMemReqReadyF (req_ready),
    .IMemAddrF     (addr),
    .IMemRspValidF (rsp_valid),
    .IMemRdataF    (rdata),
    .StallF        (stall_f),
    .StallD        (stall_d),
    .FlushD        (flush_d),
    .PCSrcE        (pcsrc_e),
    .PCTargetE     (target),
    .InstD         (inst_d),
    .PCD           (pc_d),
    .PCPlus4D      (pcp4_d),
    .ValidD        (valid_d)
  );

  int checks = 0;
  int passed = 0;
  int viol   = 0;

  typedef struct { logic [31:0] pc; bit live; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } rd_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic [31:0] pcp4; } dec_t;

  fl_t         inflight [$];
  rd_t         readyq   [$];
  dec_t        dec_log  [$];
  logic [31:0] acc_log  [$];
  logic [31:0] mem_q    [$];
  bit          mem_hold = 1'b0;
  bit          spurious = 1'b0;

  logic [31:0] m_pc   = RST_PC;
  logic [31:0] m_inst = NOP;
  logic [31:0] m_pcd  = '0;
  logic [31:0] m_pcp4 = '0;
  bit          m_vd   = 1'b0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Reference: slots in use = outstanding requests + returned-but-undecoded.
  task automatic model_step(input bit req);
    fl_t f;
    rd_t r;
    if (rst) begin
      m_pc = RST_PC; m_vd = 1'b0; m_inst = NOP; m_pcd = '0; m_pcp4 = '0;
      inflight.delete();
      readyq.delete();
    end else begin
      if (pcsrc_e || flush_d) begin
        m_vd = 1'b0; m_inst = NOP;
      end else if (!stall_d) begin
        if (readyq.size() > 0) begin
          r = readyq.pop_front();
          m_vd = 1'b1; m_inst = r.inst; m_pcd = r.pc; m_pcp4 = r.pc + 32'd4;
        end else begin
          m_vd = 1'b0; m_inst = NOP;
        end
      end
      if (rsp_valid) begin
        if (inflight.size() == 0) begin
          viol++;
          $display("note: protocol violation, response with nothing outstanding at %0t", $time);
        end else begin
          f = inflight.pop_front();
          if (f.live && !pcsrc_e) readyq.push_back('{f.pc, rdata});
        end
      end
      if (pcsrc_e) begin
        readyq.delete();
        foreach (inflight[i]) inflight[i].live = 1'b0;
        m_pc = {target[31:2], 2'b00};
      end else if (req && req_ready) begin
        inflight.push_back('{m_pc, 1'b1});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin : compare
    bit m_req;
    forever begin
      @(negedge clk);
      #4;
      m_req = !rst && !stall_f && !pcsrc_e && (inflight.size() + readyq.size() < 2);
      chk("req_valid", 32'(req_valid), 32'(m_req));
      chk("addr", addr, m_pc);
      chk("valid_d", 32'(valid_d), 32'(m_vd));
      chk("inst_d", inst_d, m_inst);
      chk("pc_d", pc_d, m_pcd);
      chk("pcp4_d", pcp4_d, m_pcp4);
      if (valid_d === 1'b1) dec_log.push_back('{pc_d, inst_d, pcp4_d});
      model_step(m_req);
    end
  end

  initial begin : memory
    rsp_valid = 1'b0;
    rdata     = '0;
    forever begin
      @(negedge clk);
      #2;
      rsp_valid = 1'b0;
      rdata     = '0;
      if (spurious) begin
        rsp_valid = 1'b1;
        rdata     = 32'hBAD0_BAD0;
      end else if (!mem_hold && mem_q.size() > 0) begin
        rsp_valid = 1'b1;
        rdata     = inst_of(mem_q.pop_front());
      end
      #2;
      if (rst) mem_q.delete();
      else if (req_valid && req_ready) begin
        mem_q.push_back(addr);
        acc_log.push_back(addr);
      end
    end
  end

  task automatic wait_dec(input int n, input string what);
    int k = 0;
    while (dec_log.size() < n && k < 200) begin
      tick(1);
      k++;
    end
    checks++;
    if (dec_log.size() >= n) passed++;
    else $display("FAIL %s: timeout, got %0d decoded expected %0d", what, dec_log.size(), n);
  endtask

  initial begin : stimulus
    int  k, idx, vb;
    bit  found;
    rst = 1'b1; req_ready = 1'b1; stall_f = 1'b0; stall_d = 1'b0;
    flush_d = 1'b0; pcsrc_e = 1'b0; target = '0;
    tick(2);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_valid_d", 32'(valid_d), 32'd0);
    chk("rst_inst_d", inst_d, NOP);
    chk("rst_pc_d", pc_d, 32'd0);
    chk("rst_pcp4_d", pcp4_d, 32'd0);
    chk("rst_addr", addr, RST_PC);

    // Straight-line streaming
    acc_log.delete(); dec_log.delete();
    rst = 1'b0;
    wait_dec(3, "stream");
    if (dec_log.size() >= 3 && acc_log.size() >= 3)
      for (int i = 0; i < 3; i++) begin
        chk("stream_acc", acc_log[i], 32'(4 * i));
        chk("stream_pc", dec_log[i].pc, 32'(4 * i));
        chk("stream_pcp4", dec_log[i].pcp4, 32'(4 * i + 4));
        chk("stream_inst", dec_log[i].inst, inst_of(32'(4 * i)));
      end

    // Responses withheld: only two requests may be outstanding
    mem_hold = 1'b1; rst = 1'b1; tick(2);
    acc_log.delete(); dec_log.delete();
    rst = 1'b0; tick(6);
    chk("held_accepts", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() >= 2) begin
      chk("held_acc0", acc_log[0], 32'h0);
      chk("held_acc1", acc_log[1], 32'h4);
    end
    chk("held_req_valid", 32'(req_valid), 32'd0);
    mem_hold = 1'b0;
    wait_dec(2, "held_release");
    if (dec_log.size() >= 2) begin
      chk("held_dec0", dec_log[0].pc, 32'h0);
      chk("held_dec1", dec_log[1].pc, 32'h4);
    end

    // Redirect with two requests in flight
    mem_hold = 1'b1; rst = 1'b1; tick(2);
    acc_log.delete();
    rst = 1'b0;
    k = 0;
    while (acc_log.size() < 2 && k < 20) begin tick(1); k++; end
    chk("redir_inflight", 32'(acc_log.size()), 32'd2);
    pcsrc_e = 1'b1; target = 32'h0000_0102;
    #1;
    chk("redir_req_valid", 32'(req_valid), 32'd0);
    tick(1);
    pcsrc_e = 1'b0; mem_hold = 1'b0;
    chk("redir_addr", addr, 32'h0000_0100);
    idx = acc_log.size(); dec_log.delete();
    wait_dec(1, "redir");
    if (dec_log.size() >= 1) begin
      chk("redir_pc", dec_log[0].pc, 32'h0000_0100);
      chk("redir_inst", dec_log[0].inst, inst_of(32'h0000_0100));
    end
    if (acc_log.size() > idx) chk("redir_acc", acc_log[idx], 32'h0000_0100);

    // Decode stall, then flush while stalled, then fetch stall
    rst = 1'b1; tick(2); rst = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 60 && !found; j++) begin
      if (valid_d === 1'b1 && pc_d === 32'h8) found = 1'b1;
      else tick(1);
    end
    chk("find_pc8", 32'(found), 32'd1);
    stall_d = 1'b1;
    repeat (3) begin
      tick(1);
      chk("hold_pc", pc_d, 32'h8);
      chk("hold_inst", inst_d, inst_of(32'h8));
      chk("hold_valid", 32'(valid_d), 32'd1);
    end
    flush_d = 1'b1;
    tick(1);
    chk("flush_valid", 32'(valid_d), 32'd0);
    chk("flush_inst", inst_d, NOP);
    chk("flush_pc", pc_d, 32'h8);
    flush_d = 1'b0; stall_d = 1'b0;
    tick(2);
    stall_f = 1'b1; tick(4);
    stall_f = 1'b0; tick(4);

    // Redirect to the top of the address space wraps to zero
    pcsrc_e = 1'b1; target = 32'hFFFF_FFFC;
    tick(1);
    pcsrc_e = 1'b0;
    idx = acc_log.size(); dec_log.delete();
    wait_dec(2, "wrap");
    if (dec_log.size() >= 2) begin
      chk("wrap_pc0", dec_log[0].pc, 32'hFFFF_FFFC);
      chk("wrap_pcp4", dec_log[0].pcp4, 32'h0);
      chk("wrap_pc1", dec_log[1].pc, 32'h0);
    end
    if (acc_log.size() > idx + 1) begin
      chk("wrap_acc0", acc_log[idx], 32'hFFFF_FFFC);
      chk("wrap_acc1", acc_log[idx + 1], 32'h0);
    end

    // Spurious response with nothing outstanding
    stall_f = 1'b1; rst = 1'b1; tick(2);
    rst = 1'b0; tick(2);
    vb = viol;
    spurious = 1'b1; tick(1);
    spurious = 1'b0; tick(2);
    chk("spur_flagged", 32'(viol - vb), 32'd1);
    chk("spur_valid", 32'(valid_d), 32'd0);
    chk("spur_inst", inst_d, NOP);
    chk("spur_req_valid", 32'(req_valid), 32'd0);
    acc_log.delete(); dec_log.delete();
    stall_f = 1'b0;
    wait_dec(1, "spur_after");
    if (dec_log.size() >= 1) begin
      chk("spur_after_pc", dec_log[0].pc, RST_PC);
      chk("spur_after_inst", dec_log[0].inst, inst_of(RST_PC));
    end
    if (acc_log.size() >= 1) chk("spur_after_acc", acc_log[0], RST_PC);

    tick(3);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule
